// File: rtl/agex_stage_pkg.sv
// Shared definitions for the LC-3b AGEX stage: control-store bit positions,
// mux/ALU encodings and a sign-extension helper.
package agex_stage_pkg;

    localparam int CS_W     = 20;
    localparam int MEM_CS_W = 11;

    localparam int CS_ADDR1MUX     = 19;
    localparam int CS_ADDR2MUX_HI  = 18;
    localparam int CS_ADDR2MUX_LO  = 17;
    localparam int CS_LSHF1        = 16;
    localparam int CS_ADDRESSMUX   = 15;
    localparam int CS_SR2MUX       = 14;
    localparam int CS_ALUK_HI      = 13;
    localparam int CS_ALUK_LO      = 12;
    localparam int CS_RESULTMUX    = 11;
    localparam int CS_BR_OP        = 10;
    localparam int CS_UNCOND_OP    = 9;
    localparam int CS_TRAP_OP      = 8;
    localparam int CS_BR_STALL     = 7;
    localparam int CS_DCACHE_EN    = 6;
    localparam int CS_DCACHE_RW    = 5;
    localparam int CS_DATA_SIZE    = 4;
    localparam int CS_DR_VALUEMUX_HI = 3;
    localparam int CS_DR_VALUEMUX_LO = 2;
    localparam int CS_LD_REG       = 1;
    localparam int CS_LD_CC        = 0;

    typedef enum logic [1:0] {
        ADDR2_ZERO  = 2'd0,
        ADDR2_OFF6  = 2'd1,
        ADDR2_OFF9  = 2'd2,
        ADDR2_OFF11 = 2'd3
    } addr2mux_e;

    typedef enum logic [1:0] {
        ALUK_ADD   = 2'd0,
        ALUK_AND   = 2'd1,
        ALUK_XOR   = 2'd2,
        ALUK_PASSB = 2'd3
    } aluk_e;

    typedef enum logic {
        SR2MUX_REG  = 1'b0,
        SR2MUX_IMM5 = 1'b1
    } sr2mux_e;

    // Sign-extend the low 'bits' bits of val to 16 bits.
    function automatic logic [15:0] sext16(input logic [15:0] val, input int unsigned bits);
        logic [15:0] shifted;
        shifted = val << (16 - bits);
        return $signed(shifted) >>> (16 - bits);
    endfunction

endpackage

// File: rtl/agex_stage_if.sv
// Decode <-> AGEX interface: instruction/operand bundle toward AGEX and
// hazard feedback back toward decode.
interface agex_stage_if;
    import agex_stage_pkg::*;

    logic            ld_agex;
    logic [15:0]     de_npc;
    logic [15:0]     de_ir;
    logic [15:0]     agex_sr1;
    logic [15:0]     agex_sr2;
    logic [2:0]      agex_drid_new;
    logic [CS_W-1:0] agex_cs;
    logic            agex_v;

    logic [2:0]      agex_drid_old;
    logic            v_agex_ld_reg;
    logic            v_agex_ld_cc;
    logic            v_agex_br_stall;

    modport master (
        output ld_agex, de_npc, de_ir, agex_sr1, agex_sr2, agex_drid_new, agex_cs, agex_v,
        input  agex_drid_old, v_agex_ld_reg, v_agex_ld_cc, v_agex_br_stall
    );

    modport slave (
        input  ld_agex, de_npc, de_ir, agex_sr1, agex_sr2, agex_drid_new, agex_cs, agex_v,
        output agex_drid_old, v_agex_ld_reg, v_agex_ld_cc, v_agex_br_stall
    );

endinterface

// File: rtl/agex_stage_alu.sv
// Combinational ALU, barrel shifter and result select for the AGEX stage.
module agex_stage_alu
    import agex_stage_pkg::*;
(
    input  logic [15:0] sr1,
    input  logic [15:0] sr2,
    input  logic [5:0]  ir_low,
    input  logic        sr2mux,
    input  logic [1:0]  aluk,
    input  logic        resultmux,
    output logic [15:0] result
);

    logic [15:0] alu_b;
    logic [15:0] alu_out;
    logic [15:0] shf_out;

    always_comb begin
        alu_b = (sr2mux_e'(sr2mux) == SR2MUX_IMM5) ? sext16({10'b0, ir_low}, 5) : sr2;
        case (aluk_e'(aluk))
            ALUK_ADD:   alu_out = sr1 + alu_b;
            ALUK_AND:   alu_out = sr1 & alu_b;
            ALUK_XOR:   alu_out = sr1 ^ alu_b;
            ALUK_PASSB: alu_out = alu_b;
            default:    alu_out = alu_b;
        endcase
    end

    // ir[5:4] = 10 is not a defined encoding and shifts logically right.
    always_comb begin
        case (ir_low[5:4])
            2'b00:   shf_out = sr1 << ir_low[3:0];
            2'b11:   shf_out = $signed(sr1) >>> ir_low[3:0];
            default: shf_out = sr1 >> ir_low[3:0];
        endcase
    end

    assign result = resultmux ? alu_out : shf_out;

endmodule

// File: rtl/agex_stage.sv
// LC-3b address-generate/execute stage: DE->AGEX and AGEX->MEM latches,
// effective-address adder and hazard feedback to decode.
module agex_stage
    import agex_stage_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                mem_stall,
    input  logic                flush,
    agex_stage_if.slave         de,
    output logic                mem_v,
    output logic [15:0]         mem_npc,
    output logic [15:0]         mem_ir,
    output logic [15:0]         mem_address,
    output logic [15:0]         mem_alu_result,
    output logic [2:0]          mem_drid,
    output logic [MEM_CS_W-1:0] mem_cs
);

    logic            agex_v_q,    agex_v_d;
    logic [15:0]     agex_npc_q,  agex_npc_d;
    logic [15:0]     agex_ir_q,   agex_ir_d;
    logic [15:0]     agex_sr1_q,  agex_sr1_d;
    logic [15:0]     agex_sr2_q,  agex_sr2_d;
    logic [2:0]      agex_drid_q, agex_drid_d;
    logic [CS_W-1:0] agex_cs_q,   agex_cs_d;

    logic                mem_v_q,          mem_v_d;
    logic [15:0]         mem_npc_q,        mem_npc_d;
    logic [15:0]         mem_ir_q,         mem_ir_d;
    logic [15:0]         mem_address_q,    mem_address_d;
    logic [15:0]         mem_alu_result_q, mem_alu_result_d;
    logic [2:0]          mem_drid_q,       mem_drid_d;
    logic [MEM_CS_W-1:0] mem_cs_q,         mem_cs_d;

    logic [15:0] addr1;
    logic [15:0] addr2;
    logic [15:0] address;
    logic [15:0] alu_result;

    always_comb begin
        addr1 = agex_cs_q[CS_ADDR1MUX] ? agex_sr1_q : agex_npc_q;
        case (addr2mux_e'(agex_cs_q[CS_ADDR2MUX_HI:CS_ADDR2MUX_LO]))
            ADDR2_ZERO:  addr2 = 16'h0000;
            ADDR2_OFF6:  addr2 = sext16(agex_ir_q, 6);
            ADDR2_OFF9:  addr2 = sext16(agex_ir_q, 9);
            ADDR2_OFF11: addr2 = sext16(agex_ir_q, 11);
            default:     addr2 = 16'h0000;
        endcase
        if (agex_cs_q[CS_LSHF1]) begin
            addr2 = addr2 << 1;
        end
        address = agex_cs_q[CS_ADDRESSMUX] ? (addr1 + addr2) : {7'b0, agex_ir_q[7:0], 1'b0};
    end

    agex_stage_alu u_alu (
        .sr1       (agex_sr1_q),
        .sr2       (agex_sr2_q),
        .ir_low    (agex_ir_q[5:0]),
        .sr2mux    (agex_cs_q[CS_SR2MUX]),
        .aluk      (agex_cs_q[CS_ALUK_HI:CS_ALUK_LO]),
        .resultmux (agex_cs_q[CS_RESULTMUX]),
        .result    (alu_result)
    );

    // Flush only kills the valid bits; data paths follow their own load/stall enables.
    always_comb begin
        agex_v_d    = agex_v_q;
        agex_npc_d  = agex_npc_q;
        agex_ir_d   = agex_ir_q;
        agex_sr1_d  = agex_sr1_q;
        agex_sr2_d  = agex_sr2_q;
        agex_drid_d = agex_drid_q;
        agex_cs_d   = agex_cs_q;
        if (de.ld_agex) begin
            agex_v_d    = de.agex_v;
            agex_npc_d  = de.de_npc;
            agex_ir_d   = de.de_ir;
            agex_sr1_d  = de.agex_sr1;
            agex_sr2_d  = de.agex_sr2;
            agex_drid_d = de.agex_drid_new;
            agex_cs_d   = de.agex_cs;
        end
        if (flush) begin
            agex_v_d = 1'b0;
        end

        mem_v_d          = mem_v_q;
        mem_npc_d        = mem_npc_q;
        mem_ir_d         = mem_ir_q;
        mem_address_d    = mem_address_q;
        mem_alu_result_d = mem_alu_result_q;
        mem_drid_d       = mem_drid_q;
        mem_cs_d         = mem_cs_q;
        if (!mem_stall) begin
            mem_v_d          = agex_v_q;
            mem_npc_d        = agex_npc_q;
            mem_ir_d         = agex_ir_q;
            mem_address_d    = address;
            mem_alu_result_d = alu_result;
            mem_drid_d       = agex_drid_q;
            mem_cs_d         = agex_cs_q[MEM_CS_W-1:0];
        end
        if (flush) begin
            mem_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            agex_v_q         <= 1'b0;
            agex_npc_q       <= '0;
            agex_ir_q        <= '0;
            agex_sr1_q       <= '0;
            agex_sr2_q       <= '0;
            agex_drid_q      <= '0;
            agex_cs_q        <= '0;
            mem_v_q          <= 1'b0;
            mem_npc_q        <= '0;
            mem_ir_q         <= '0;
            mem_address_q    <= '0;
            mem_alu_result_q <= '0;
            mem_drid_q       <= '0;
            mem_cs_q         <= '0;
        end else begin
            agex_v_q         <= agex_v_d;
            agex_npc_q       <= agex_npc_d;
            agex_ir_q        <= agex_ir_d;
            agex_sr1_q       <= agex_sr1_d;
            agex_sr2_q       <= agex_sr2_d;
            agex_drid_q      <= agex_drid_d;
            agex_cs_q        <= agex_cs_d;
            mem_v_q          <= mem_v_d;
            mem_npc_q        <= mem_npc_d;
            mem_ir_q         <= mem_ir_d;
            mem_address_q    <= mem_address_d;
            mem_alu_result_q <= mem_alu_result_d;
            mem_drid_q       <= mem_drid_d;
            mem_cs_q         <= mem_cs_d;
        end
    end

    assign de.agex_drid_old   = agex_drid_q;
    assign de.v_agex_ld_reg   = agex_v_q & agex_cs_q[CS_LD_REG];
    assign de.v_agex_ld_cc    = agex_v_q & agex_cs_q[CS_LD_CC];
    assign de.v_agex_br_stall = agex_v_q & agex_cs_q[CS_BR_STALL];

    assign mem_v          = mem_v_q;
    assign mem_npc        = mem_npc_q;
    assign mem_ir         = mem_ir_q;
    assign mem_address    = mem_address_q;
    assign mem_alu_result = mem_alu_result_q;
    assign mem_drid       = mem_drid_q;
    assign mem_cs         = mem_cs_q;

endmodule

// File: tb/tb_agex_stage.sv
// Directed testbench for agex_stage with a queue scoreboard of expected MEM-latch contents.
module tb_agex_stage;
    import agex_stage_pkg::*;

    typedef struct packed {
        logic [15:0] npc;
        logic [15:0] ir;
        logic [15:0] sr1;
        logic [15:0] sr2;
        logic [2:0]  drid;
        logic [19:0] cs;
        logic        v;
        logic [15:0] addr;
        logic [15:0] alu;
    } instr_t;

    typedef struct packed {
        logic [15:0] npc;
        logic [15:0] ir;
        logic [15:0] addr;
        logic [15:0] alu;
        logic [2:0]  drid;
        logic [10:0] cs;
    } mem_exp_t;

    logic clk = 1'b0;
    logic reset;
    logic mem_stall;
    logic flush;
    logic        mem_v;
    logic [15:0] mem_npc, mem_ir, mem_address, mem_alu_result;
    logic [2:0]  mem_drid;
    logic [10:0] mem_cs;

    int errors = 0;
    int checks = 0;
    instr_t   sb[$];
    mem_exp_t last_exp;
    instr_t   dropped;

    agex_stage_if de_if ();

    agex_stage dut (
        .clk            (clk),
        .reset          (reset),
        .mem_stall      (mem_stall),
        .flush          (flush),
        .de             (de_if.slave),
        .mem_v          (mem_v),
        .mem_npc        (mem_npc),
        .mem_ir         (mem_ir),
        .mem_address    (mem_address),
        .mem_alu_result (mem_alu_result),
        .mem_drid       (mem_drid),
        .mem_cs         (mem_cs)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] mkCs(input logic a1, input logic [1:0] a2, input logic lshf,
                                         input logic amux, input logic s2mux, input logic [1:0] aluk,
                                         input logic rmux, input logic [10:0] low);
        return {a1, a2, lshf, amux, s2mux, aluk, rmux, low};
    endfunction

    function automatic instr_t mk(input logic [15:0] npc, input logic [15:0] ir, input logic [15:0] sr1,
                                  input logic [15:0] sr2, input logic [2:0] drid, input logic [19:0] cs,
                                  input logic v, input logic [15:0] addr, input logic [15:0] alu);
        instr_t t;
        t.npc = npc; t.ir = ir; t.sr1 = sr1; t.sr2 = sr2; t.drid = drid;
        t.cs = cs; t.v = v; t.addr = addr; t.alu = alu;
        return t;
    endfunction

    function automatic mem_exp_t expOf(input instr_t t);
        return {t.npc, t.ir, t.addr, t.alu, t.drid, t.cs[10:0]};
    endfunction

    function automatic mem_exp_t obsMem();
        return {mem_npc, mem_ir, mem_address, mem_alu_result, mem_drid, mem_cs};
    endfunction

    task automatic checkOutput(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input instr_t t, input logic load, input logic push);
        de_if.ld_agex       = load;
        de_if.de_npc        = t.npc;
        de_if.de_ir         = t.ir;
        de_if.agex_sr1      = t.sr1;
        de_if.agex_sr2      = t.sr2;
        de_if.agex_drid_new = t.drid;
        de_if.agex_cs       = t.cs;
        de_if.agex_v        = t.v;
        if (load && push && t.v) sb.push_back(t);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic popCompare(input string tag, input logic exp_v);
        instr_t e;
        checkOutput({tag, "_valid"}, 96'(mem_v), 96'(exp_v));
        if (exp_v) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("[TB] FAIL %s: observed=empty scoreboard expected=pending entry", tag);
            end else begin
                e = sb.pop_front();
                last_exp = expOf(e);
                checkOutput(tag, 96'(obsMem()), 96'(last_exp));
            end
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_mem"}, 96'(obsMem()), 96'(0));
        checkOutput({tag, "_mem_v"}, 96'(mem_v), 96'(0));
        checkOutput({tag, "_fb"}, 96'({de_if.agex_drid_old, de_if.v_agex_ld_reg,
                                        de_if.v_agex_ld_cc, de_if.v_agex_br_stall}), 96'(0));
    endtask

    initial begin
        instr_t i_add, i_and, i_br, i_rsha, i_lshf, i_rshl, i_xor, i_passb, i_wrap, i_off9, i_inval, i_bub;
        i_add   = mk(16'h3002, 16'h1242, 16'h0005, 16'h0003, 3'd1, mkCs(0, 0, 0, 1, 0, 0, 1, 11'h003), 1, 16'h3002, 16'h0008);
        i_and   = mk(16'h3004, 16'h507F, 16'h1234, 16'h0000, 3'd2, mkCs(1, 0, 0, 1, 1, 1, 1, 11'h003), 1, 16'h1234, 16'h1234);
        i_br    = mk(16'h3000, 16'h01FF, 16'h0010, 16'h0001, 3'd7, mkCs(0, 2, 1, 1, 0, 0, 1, 11'h480), 1, 16'h2FFE, 16'h0011);
        i_rsha  = mk(16'h3006, 16'hD034, 16'h8000, 16'h0000, 3'd3, mkCs(0, 0, 0, 1, 0, 0, 0, 11'h003), 1, 16'h3006, 16'hF800);
        i_lshf  = mk(16'h3008, 16'hD00F, 16'h0003, 16'h0000, 3'd4, mkCs(0, 0, 0, 1, 0, 0, 0, 11'h003), 1, 16'h3008, 16'h8000);
        i_rshl  = mk(16'h300A, 16'hD022, 16'h8000, 16'h0000, 3'd5, mkCs(0, 0, 0, 1, 0, 0, 0, 11'h003), 1, 16'h300A, 16'h2000);
        i_xor   = mk(16'h300C, 16'h903E, 16'h00FF, 16'h0F0F, 3'd6, mkCs(1, 1, 0, 1, 0, 2, 1, 11'h003), 1, 16'h00FD, 16'h0FF0);
        i_passb = mk(16'h300E, 16'h5030, 16'h1111, 16'h2222, 3'd0, mkCs(0, 0, 0, 0, 1, 3, 1, 11'h003), 1, 16'h0060, 16'hFFF0);
        i_wrap  = mk(16'h3010, 16'h4C00, 16'hFFFF, 16'h0002, 3'd1, mkCs(0, 3, 1, 1, 0, 0, 1, 11'h202), 1, 16'h2810, 16'h0001);
        i_off9  = mk(16'h3012, 16'h00FF, 16'h4000, 16'h4F00, 3'd2, mkCs(1, 2, 0, 1, 0, 1, 1, 11'h070), 1, 16'h40FF, 16'h4000);
        i_inval = mk(16'h3014, 16'h1242, 16'h0001, 16'h0001, 3'd5, mkCs(0, 0, 0, 1, 0, 0, 1, 11'h003), 0, 16'h0000, 16'h0000);
        i_bub   = mk(16'h0000, 16'h0000, 16'h0000, 16'h0000, 3'd0, 20'h0, 0, 16'h0000, 16'h0000);

        reset = 1'b1;
        mem_stall = 1'b0;
        flush = 1'b0;
        applyStimulus(i_bub, 1, 0);
        #3;
        checkAllZero("reset");
        @(negedge clk);
        reset = 1'b0;

        applyStimulus(i_add, 1, 1);   tick(); popCompare("fill", 0);
        checkOutput("add_fb", 96'({de_if.agex_drid_old, de_if.v_agex_ld_reg, de_if.v_agex_ld_cc, de_if.v_agex_br_stall}),
                    96'({3'd1, 1'b1, 1'b1, 1'b0}));
        applyStimulus(i_and, 1, 1);   tick(); popCompare("add_reg", 1);
        applyStimulus(i_br, 1, 1);    tick(); popCompare("and_imm", 1);
        checkOutput("br_fb", 96'({de_if.v_agex_ld_reg, de_if.v_agex_br_stall}), 96'({1'b0, 1'b1}));
        applyStimulus(i_rsha, 1, 1);  tick(); popCompare("br_addr", 1);
        checkOutput("br_stall_gone", 96'(de_if.v_agex_br_stall), 96'(0));
        applyStimulus(i_lshf, 1, 1);  tick(); popCompare("rshfa", 1);
        applyStimulus(i_rshl, 1, 1);  tick(); popCompare("lshf15", 1);
        applyStimulus(i_xor, 1, 1);   tick(); popCompare("rshfl_10", 1);
        applyStimulus(i_passb, 1, 1); tick(); popCompare("xor_off6", 1);
        applyStimulus(i_wrap, 1, 1);  tick(); popCompare("passb_trap", 1);
        applyStimulus(i_off9, 1, 1);  tick(); popCompare("add_wrap_off11", 1);
        applyStimulus(i_inval, 1, 1); tick(); popCompare("and_off9", 1);
        checkOutput("inval_fb", 96'({de_if.agex_drid_old, de_if.v_agex_ld_reg, de_if.v_agex_ld_cc}),
                    96'({3'd5, 1'b0, 1'b0}));
        applyStimulus(i_add, 1, 1);   tick(); popCompare("inval_bubble", 0);
        applyStimulus(i_and, 1, 1);   tick(); popCompare("add_again", 1);

        // Hold both latches for three edges while decode presents a new instruction.
        mem_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(i_br, 0, 0);
            tick();
            checkOutput("stall_mem_hold", 96'({mem_v, obsMem()}), 96'({1'b1, last_exp}));
            checkOutput("stall_agex_hold", 96'({de_if.agex_drid_old, de_if.v_agex_ld_reg, de_if.v_agex_br_stall}),
                        96'({3'd2, 1'b1, 1'b0}));
        end
        mem_stall = 1'b0;
        applyStimulus(i_br, 1, 1);    tick(); popCompare("stall_release", 1);

        // Flush together with stall: valid bits clear, data holds.
        mem_stall = 1'b1;
        flush = 1'b1;
        applyStimulus(i_rsha, 0, 0);  tick();
        checkOutput("flush_stall_mem", 96'({mem_v, obsMem()}), 96'({1'b0, last_exp}));
        checkOutput("flush_stall_agex", 96'({de_if.agex_drid_old, de_if.v_agex_br_stall}), 96'({3'd7, 1'b0}));
        dropped = sb.pop_front();
        mem_stall = 1'b0;
        flush = 1'b0;
        applyStimulus(i_add, 1, 1);   tick(); popCompare("after_flush_stall", 0);

        // Plain flush with a valid instruction in AGEX.
        flush = 1'b1;
        applyStimulus(i_xor, 1, 0);   tick(); popCompare("flush", 0);
        checkOutput("flush_fb", 96'({de_if.agex_drid_old, de_if.v_agex_ld_reg}), 96'({3'd6, 1'b0}));
        dropped = sb.pop_front();
        flush = 1'b0;
        applyStimulus(i_and, 1, 1);   tick(); popCompare("post_flush_bubble", 0);
        applyStimulus(i_passb, 1, 1); tick(); popCompare("pre_reset", 1);

        // Asynchronous reset in the middle of a cycle.
        #2;
        reset = 1'b1;
        #1;
        checkAllZero("reset_async");
        sb.delete();
        tick();
        checkAllZero("reset_held");
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(i_add, 1, 1);   tick(); popCompare("post_reset_fill", 0);
        applyStimulus(i_bub, 1, 0);   tick(); popCompare("post_reset_add", 1);
        checkOutput("sb_drained", 96'(sb.size()), 96'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
